gravity_tick_scheduler: RTL and testbench

Controller that sequences piece-gravity timing for the Tetris core. It divides the system clock into sub-ticks with a prescaler, then into gravity periods whose length is set by the current level and the soft-drop input. It issues one-cycle `drop_tick` strobes to the piece-movement logic and owns the run/pause/game-over sequencing of that timebase. It uses clock-enable pulses only and generates no derived clocks.

---
 rtl/gravity_tick_scheduler.sv | 61 ++++++
 tb/tb_gravity_tick_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gravity_tick_scheduler.sv
// gravity_tick_scheduler: prescaled gravity timebase with run/pause/over sequencing; in clk,rst_n,start,pause_req,game_over,soft_drop,level -> out drop_tick,running,paused,cur_period
module gravity_tick_scheduler #(
  parameter int PRESCALE    = 250000,
  parameter int BASE_PERIOD = 800,
  parameter int STEP        = 50,
  parameter int MIN_PERIOD  = 100,
  parameter int SOFT_PERIOD = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause_req,
  input  logic        game_over,
  input  logic        soft_drop,
  input  logic [3:0]  level,
  output logic        drop_tick,
  output logic        running,
  output logic        paused,
  output logic [15:0] cur_period
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pre_cnt, pre_nx;
  logic [15:0] sub_cnt, sub_nx, lvl_period;
  logic [31:0] prod;
  logic count, sub_edge, fire, fresh;
  assign prod = 32'(level) * 32'(STEP);
  assign lvl_period = prod > 32'(BASE_PERIOD - MIN_PERIOD) ? 16'(MIN_PERIOD) : 16'(32'(BASE_PERIOD) - prod);
  assign cur_period = soft_drop && lvl_period > 16'(SOFT_PERIOD) ? 16'(SOFT_PERIOD) : lvl_period;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? RUN : IDLE;
      RUN:   state_nx = game_over ? OVER : pause_req ? PAUSE : RUN;
      PAUSE: state_nx = game_over ? OVER : pause_req ? RUN : PAUSE;
      OVER:  state_nx = start ? RUN : OVER;
    endcase
  end
  assign count    = state == RUN && state_nx == RUN;
  assign sub_edge = count && pre_cnt == PW'(PRESCALE - 1);
  assign fire     = sub_edge && ({1'b0, sub_cnt} + 17'd1 >= {1'b0, cur_period});
  assign fresh    = state_nx == RUN && (state == IDLE || state == OVER);
  assign pre_nx   = fresh || sub_edge ? '0 : count ? pre_cnt + 1'b1 : pre_cnt;
  assign sub_nx   = fresh || fire ? '0 : sub_edge ? sub_cnt + 16'd1 : sub_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      sub_cnt   <= '0;
      drop_tick <= 1'b0;
    end else begin
      state     <= state_nx;
      pre_cnt   <= pre_nx;
      sub_cnt   <= sub_nx;
      drop_tick <= fire;
    end
  end
  assign running = state == RUN;
  assign paused  = state == PAUSE;
endmodule

// File: tb/tb_gravity_tick_scheduler.sv
// tb_gravity_tick_scheduler: scoreboard bench with a cycle reference model for gravity_tick_scheduler
module tb_gravity_tick_scheduler;
  localparam int P = 4, BASE = 8, STP = 1, MINP = 2, SOFT = 1;
  logic clk = 0, rst_n = 0, start = 0, pause_req = 0, game_over = 0, soft_drop = 0;
  logic [3:0] level = 0;
  logic drop_tick, running, paused;
  logic [15:0] cur_period;
  int checks = 0, fails = 0;
  logic [18:0] q[$];
  logic [18:0] e;
  int mst = 0, mn = 0, ms = 0;
  bit mtick = 0;
  gravity_tick_scheduler #(.PRESCALE(P), .BASE_PERIOD(BASE), .STEP(STP), .MIN_PERIOD(MINP), .SOFT_PERIOD(SOFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause_req(pause_req), .game_over(game_over),
    .soft_drop(soft_drop), .level(level), .drop_tick(drop_tick), .running(running),
    .paused(paused), .cur_period(cur_period)
  );
  always #5 clk = ~clk;
  function automatic int eff(int lv, bit sd);
    int lp;
    lp = (lv * STP > BASE - MINP) ? MINP : BASE - lv * STP;
    return sd ? (lp < SOFT ? lp : SOFT) : lp;
  endfunction
  task automatic model_step();
    int nst;
    if (!rst_n) begin
      mst = 0; mn = 0; ms = 0; mtick = 0;
    end else begin
      nst = mst;
      if (mst == 0 && start) nst = 1;
      else if (mst == 1) nst = game_over ? 3 : pause_req ? 2 : 1;
      else if (mst == 2) nst = game_over ? 3 : pause_req ? 1 : 2;
      else if (mst == 3 && start) nst = 1;
      mtick = 0;
      if (mst == 1 && nst == 1) begin
        mn++;
        if (mn % P == 0) begin
          if (ms + 1 >= eff(level, soft_drop)) begin ms = 0; mtick = 1; end
          else ms++;
        end
      end
      if (nst == 1 && (mst == 0 || mst == 3)) begin mn = 0; ms = 0; end
      mst = nst;
    end
    q.push_back({mtick, mst == 1, mst == 2, 16'(eff(level, soft_drop))});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({drop_tick, running, paused, cur_period} !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got tick=%b run=%b pause=%b per=%0d expected tick=%b run=%b pause=%b per=%0d",
                 $time, drop_tick, running, paused, cur_period, e[18], e[17], e[16], e[15:0]);
      end
    end
  end
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic cycle(input bit st, input bit pr, input bit go);
    start = st; pause_req = pr; game_over = go;
    model_step();
    @(negedge clk);
    start = 0; pause_req = 0; game_over = 0;
  endtask
  task automatic wait_tick(int exp, string nm);
    int n = 0;
    do begin cycle(0, 0, 0); n++; end while (!drop_tick && n < 300);
    chk(nm, n, exp);
  endtask
  initial begin
    int tk;
    @(negedge clk);
    chk("reset tick", drop_tick, 0);
    chk("reset running", running, 0);
    chk("reset paused", paused, 0);
    chk("reset period", cur_period, 8);
    rst_n = 1;
    cycle(0, 1, 1);
    cycle(1, 0, 0);
    chk("start running", running, 1);
    wait_tick(32, "first tick");
    cycle(0, 0, 0);
    chk("tick width", drop_tick, 0);
    wait_tick(31, "tick period");
    wait_tick(32, "tick period 2");
    level = 10;
    #1 chk("clamped period", cur_period, 2);
    wait_tick(8, "level10 tick");
    wait_tick(8, "level10 tick 2");
    level = 3;
    #1 chk("level3 period", cur_period, 5);
    wait_tick(20, "level3 tick");
    level = 0; soft_drop = 1;
    #1 chk("soft period", cur_period, 1);
    wait_tick(4, "soft tick");
    wait_tick(4, "soft tick 2");
    soft_drop = 0;
    wait_tick(32, "soft release tick");
    cycle(0, 0, 1);
    chk("over running", running, 0);
    cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("paused", paused, 1);
    tk = 0;
    repeat (100) begin cycle(0, 0, 0); tk += int'(drop_tick); end
    chk("ticks in pause", tk, 0);
    cycle(0, 1, 0);
    chk("resumed", running, 1);
    wait_tick(12, "resume tick");
    cycle(0, 1, 1);
    chk("go+pause running", running, 0);
    chk("go+pause paused", paused, 0);
    cycle(1, 0, 0);
    wait_tick(32, "restart tick");
    #2 rst_n = 0;
    #1 chk("async running", running, 0);
    chk("async tick", drop_tick, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("start in reset", running, 0);
    rst_n = 1;
    repeat (3) cycle(0, 0, 0);
    chk("needs start", running, 0);
    repeat (4000) begin
      if ($urandom_range(0, 29) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) soft_drop = ~soft_drop;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        #1 chk("random async reset", running, 0);
        cycle(1, 0, 0);
        rst_n = 1;
      end else
        cycle($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    chk("queue drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
